// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the fetch port and the data port (data has priority).
// Optional fetch anti-starvation guard: define ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
`ifdef ARB_STARVE_GUARD_EN
  ,
  parameter int unsigned STARVE_MAX = 4
`endif
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_owner_dm;
  logic              r_we;

  logic [1:0]        w_state_nx;
  logic [CNT_W-1:0]  w_cnt_nx;
  logic              w_owner_dm_nx;
  logic              w_we_nx;
  logic              w_if_gnt_nx;
  logic              w_dm_gnt_nx;
  logic              w_if_rvalid_nx;
  logic              w_dm_rvalid_nx;
  logic [DATA_W-1:0] w_if_rdata_nx;
  logic [DATA_W-1:0] w_dm_rdata_nx;
  logic              w_mem_en_nx;
  logic              w_mem_we_nx;
  logic [ADDR_W-1:0] w_mem_addr_nx;
  logic [DATA_W-1:0] w_mem_wdata_nx;
  logic              w_busy_nx;
  logic              w_arb;
  logic              w_force_if;
  logic              w_grant_dm;
  logic              w_grant_if;

  assign w_arb      = (r_state == S_IDLE) || (r_state == S_RESP);
  assign w_grant_dm = dm_req & ~w_force_if;
  assign w_grant_if = if_req & ~w_grant_dm;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

  logic [STARVE_W-1:0] r_starve;
  logic [STARVE_W-1:0] w_starve_nx;

  assign w_force_if = if_req && (r_starve >= STARVE_W'(STARVE_MAX));

  // Count data grants that overtook a waiting fetch; any fetch grant or idle fetch port clears it
  always_comb begin
    w_starve_nx = if_req ? r_starve : '0;
    if (w_arb) begin
      if (w_grant_if) begin
        w_starve_nx = '0;
      end else if (w_grant_dm && if_req) begin
        w_starve_nx = r_starve + STARVE_W'(1);
      end
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_starve <= '0;
    end else begin
      r_starve <= w_starve_nx;
    end
  end
`else
  assign w_force_if = 1'b0;
`endif

  // Next state and next registered outputs
  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = r_cnt;
    w_owner_dm_nx  = r_owner_dm;
    w_we_nx        = r_we;
    w_if_gnt_nx    = 1'b0;
    w_dm_gnt_nx    = 1'b0;
    w_if_rvalid_nx = 1'b0;
    w_dm_rvalid_nx = 1'b0;
    w_if_rdata_nx  = if_rdata;
    w_dm_rdata_nx  = dm_rdata;
    w_mem_en_nx    = 1'b0;
    w_mem_we_nx    = 1'b0;
    w_mem_addr_nx  = mem_addr;
    w_mem_wdata_nx = mem_wdata;
    w_busy_nx      = 1'b0;
    case (r_state)
      S_IDLE, S_RESP: begin
        if (w_grant_dm || w_grant_if) begin
          w_state_nx    = S_ACCESS;
          w_owner_dm_nx = w_grant_dm;
          w_we_nx       = w_grant_dm & dm_we;
          w_dm_gnt_nx   = w_grant_dm;
          w_if_gnt_nx   = w_grant_if;
          w_mem_en_nx   = 1'b1;
          w_mem_we_nx   = w_grant_dm & dm_we;
          w_mem_addr_nx = w_grant_dm ? dm_addr : if_addr;
          if (w_grant_dm) begin
            w_mem_wdata_nx = dm_wdata;
          end
          w_busy_nx     = 1'b1;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_ACCESS: begin
        w_state_nx = S_WAIT;
        w_cnt_nx   = CNT_W'(1);
        w_busy_nx  = 1'b1;
      end
      S_WAIT: begin
        if (r_cnt == CNT_W'(MEM_LAT)) begin
          w_state_nx = S_RESP;
          w_cnt_nx   = '0;
          if (r_owner_dm) begin
            w_dm_rvalid_nx = 1'b1;
            if (!r_we) begin
              w_dm_rdata_nx = mem_rdata;
            end
          end else begin
            w_if_rvalid_nx = 1'b1;
            w_if_rdata_nx  = mem_rdata;
          end
        end else begin
          w_cnt_nx  = r_cnt + CNT_W'(1);
          w_busy_nx = 1'b1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_owner_dm <= 1'b0;
      r_we       <= 1'b0;
      if_gnt     <= 1'b0;
      dm_gnt     <= 1'b0;
      if_rvalid  <= 1'b0;
      dm_rvalid  <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_owner_dm <= w_owner_dm_nx;
      r_we       <= w_we_nx;
      if_gnt     <= w_if_gnt_nx;
      dm_gnt     <= w_dm_gnt_nx;
      if_rvalid  <= w_if_rvalid_nx;
      dm_rvalid  <= w_dm_rvalid_nx;
      if_rdata   <= w_if_rdata_nx;
      dm_rdata   <= w_dm_rdata_nx;
      mem_en     <= w_mem_en_nx;
      mem_we     <= w_mem_we_nx;
      mem_addr   <= w_mem_addr_nx;
      mem_wdata  <= w_mem_wdata_nx;
      busy       <= w_busy_nx;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a 2-cycle-latency memory model.
module tb_mem_port_arbiter;

  localparam int MEM_LAT = 2;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk1 = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we;
  logic [9:0]  if_addr, dm_addr;
  logic [31:0] dm_wdata;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid;
  logic [31:0] if_rdata, dm_rdata;
  logic        mem_en, mem_we, busy;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  typedef struct { int cyc; bit is_dm; } gnt_t;
  typedef struct { int cyc; logic [9:0] addr; bit we; logic [31:0] wdata; } mem_t;
  typedef struct { int cyc; bit is_dm; logic [31:0] data; } rv_t;

  gnt_t q_gnt[$];
  mem_t q_mem[$];
  rv_t  q_rv[$];

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int lg = -1000;
  bit end_req = 1'b0;
  bit preload = 1'b1;

  mem_port_arbiter dut (
    .clk1(clk1), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk1 = ~clk1;
  always @(posedge clk1) cyc <= cyc + 1;

  // Memory model: read data appears two cycles after the mem_en cycle
  logic [31:0] mem [1024];
  logic [31:0] rd1;
  always @(posedge clk1) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[5] <= 32'hDEADBEEF;
    end else if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    rd1       <= mem[mem_addr];
    mem_rdata <= rd1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h, required %0h", name, cyc, act, exp);
    end
  endtask

  task automatic flag(input string name, input string what);
    n_cmp++;
    n_bad++;
    $display("FAIL %s @cycle %0d: %s", name, cyc, what);
  endtask

  // Monitor: pops expectations whenever the DUT pulses, plus per-cycle invariants
  always @(negedge clk1) begin
    gnt_t g;
    mem_t m;
    rv_t  r;
    if (rst) begin
      chk("rst_ctrl", 64'({if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, busy}), 64'h0);
      chk("rst_rdata", {if_rdata, dm_rdata}, 64'h0);
      chk("rst_mem", 64'({mem_addr, mem_wdata}), 64'h0);
      lg = -1000;
    end else begin
      while (q_gnt.size() != 0 && q_gnt[0].cyc < cyc) begin
        flag("gnt_missing", $sformatf("no gnt seen, required at cycle %0d", q_gnt[0].cyc));
        void'(q_gnt.pop_front());
      end
      while (q_mem.size() != 0 && q_mem[0].cyc < cyc) begin
        flag("mem_en_missing", $sformatf("no mem_en seen, required at cycle %0d", q_mem[0].cyc));
        void'(q_mem.pop_front());
      end
      while (q_rv.size() != 0 && q_rv[0].cyc < cyc) begin
        flag("rvalid_missing", $sformatf("no rvalid seen, required at cycle %0d", q_rv[0].cyc));
        void'(q_rv.pop_front());
      end

      chk("single_gnt", 64'(if_gnt & dm_gnt), 64'h0);
      chk("we_implies_en", 64'(mem_we & ~mem_en), 64'h0);

      if (if_gnt || dm_gnt) begin
        lg = cyc;
        if (q_gnt.size() == 0) begin
          flag("unexpected_gnt", "gnt pulse seen, required none");
        end else begin
          g = q_gnt.pop_front();
          chk("gnt_cycle", 64'(cyc), 64'(g.cyc));
          chk("gnt_port_dm", 64'(dm_gnt), 64'(g.is_dm));
        end
      end

      if (mem_en) begin
        if (q_mem.size() == 0) begin
          flag("unexpected_mem_en", "mem_en seen, required none");
        end else begin
          m = q_mem.pop_front();
          chk("mem_cycle", 64'(cyc), 64'(m.cyc));
          chk("mem_addr", 64'(mem_addr), 64'(m.addr));
          chk("mem_we", 64'(mem_we), 64'(m.we));
          if (m.we) chk("mem_wdata", 64'(mem_wdata), 64'(m.wdata));
        end
      end

      chk("busy", 64'(busy), 64'(cyc >= lg && cyc <= lg + MEM_LAT));

      if (if_rvalid || dm_rvalid) begin
        chk("rvalid_after_wait", 64'(cyc), 64'(lg + MEM_LAT + 1));
        if (q_rv.size() == 0) begin
          flag("unexpected_rvalid", "rvalid pulse seen, required none");
        end else begin
          r = q_rv.pop_front();
          chk("rv_cycle", 64'(cyc), 64'(r.cyc));
          chk("rv_port_dm", 64'({dm_rvalid, if_rvalid}), r.is_dm ? 64'h2 : 64'h1);
          chk("rv_data", 64'(r.is_dm ? dm_rdata : if_rdata), 64'(r.data));
        end
      end

      if (end_req) begin
        chk("pending_expectations", 64'(q_gnt.size() + q_mem.size() + q_rv.size()), 64'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic expect_access(input int c, input bit is_dm, input logic [9:0] a,
                               input bit we, input logic [31:0] wd);
    q_gnt.push_back('{c, is_dm});
    q_mem.push_back('{c, a, we, wd});
  endtask

  initial begin
    int c0;
    bit is_dm;
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    repeat (3) @(posedge clk1);
    #1;
    rst = 1'b0;
    preload = 1'b0;
    repeat (2) tick();

    // Fetch of a preloaded word
    c0 = cyc;
    if_req = 1'b1; if_addr = 10'h005;
    expect_access(c0 + 1, 1'b0, 10'h005, 1'b0, 32'h0);
    q_rv.push_back('{c0 + 4, 1'b0, 32'hDEADBEEF});
    repeat (2) tick();
    if_req = 1'b0;
    repeat (5) tick();

    // Store to the top address; dm_rdata keeps its reset value
    c0 = cyc;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'h3FF; dm_wdata = 32'h12345678;
    expect_access(c0 + 1, 1'b1, 10'h3FF, 1'b1, 32'h12345678);
    q_rv.push_back('{c0 + 4, 1'b1, 32'h0});
    repeat (2) tick();
    dm_req = 1'b0; dm_we = 1'b0;
    repeat (5) tick();

    // Fetch back the stored word
    c0 = cyc;
    if_req = 1'b1; if_addr = 10'h3FF;
    expect_access(c0 + 1, 1'b0, 10'h3FF, 1'b0, 32'h0);
    q_rv.push_back('{c0 + 4, 1'b0, 32'h12345678});
    repeat (2) tick();
    if_req = 1'b0;
    repeat (5) tick();

    // Simultaneous requests: load first, fetch from the following RESP
    c0 = cyc;
    if_req = 1'b1; if_addr = 10'h3FF;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h005;
    expect_access(c0 + 1, 1'b1, 10'h005, 1'b0, 32'h0);
    q_rv.push_back('{c0 + 4, 1'b1, 32'hDEADBEEF});
    expect_access(c0 + 5, 1'b0, 10'h3FF, 1'b0, 32'h0);
    q_rv.push_back('{c0 + 8, 1'b0, 32'h12345678});
    repeat (2) tick();
    dm_req = 1'b0;
    repeat (4) tick();
    if_req = 1'b0;
    repeat (5) tick();

    // Both ports held for 20 accesses
    c0 = cyc;
    if_req = 1'b1; if_addr = 10'h3FF;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h005;
    for (int k = 0; k < 20; k++) begin
      is_dm = !(GUARD && (k % 5 == 4));
      expect_access(c0 + 1 + 4 * k, is_dm, is_dm ? 10'h005 : 10'h3FF, 1'b0, 32'h0);
      q_rv.push_back('{c0 + 4 + 4 * k, is_dm, is_dm ? 32'hDEADBEEF : 32'h12345678});
    end
    while (cyc < c0 + 78) tick();
    if_req = 1'b0;
    dm_req = 1'b0;
    repeat (6) tick();

    // Reset during WAIT of a load drops the access
    c0 = cyc;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h005;
    expect_access(c0 + 1, 1'b1, 10'h005, 1'b0, 32'h0);
    repeat (2) tick();
    dm_req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (6) tick();

    // Next request after reset keeps normal timing
    c0 = cyc;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h3FF;
    expect_access(c0 + 1, 1'b1, 10'h3FF, 1'b0, 32'h0);
    q_rv.push_back('{c0 + 4, 1'b1, 32'h12345678});
    repeat (2) tick();
    dm_req = 1'b0;
    repeat (5) tick();

    end_req = 1'b1;
    @(negedge clk1);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
